serial_subtractor: RTL and testbench

Multi-cycle bit-serial subtractor that computes `a - b - bin` one bit per clock using a single full-subtractor cell. It is the inverse-arithmetic counterpart to the ripple adder datapath. It sits beside the adder in the arithmetic unit and trades latency for area. It accepts operands on a one-cycle `start` strobe and reports the result with a one-cycle `done` pulse.

---
 rtl/serial_sub_pkg.sv | 16 +
 rtl/full_subtractor_beh.sv | 13 +
 rtl/serial_subtractor.sv | 136 +++++++++++++
 tb/tb_serial_subtractor.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the bit-counter width helper.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // A width of 1 would give a zero-bit counter, so clamp to one bit.
    function automatic int cnt_w(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/full_subtractor_beh.sv
// Single-bit full subtractor cell: D = x - y - bi, Bo = borrow out.
module full_subtractor_beh (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic D,
    output logic Bo
);

    assign D  = x ^ y ^ bi;
    assign Bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor computing a - b - bin one bit per clock, LSB first.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] res_shift;
    logic             br_q, br_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             accept;
    logic             cell_d;
    logic             cell_bo;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    full_subtractor_beh u_cell (
        .x  (a_sr_q[0]),
        .y  (b_sr_q[0]),
        .bi (br_q),
        .D  (cell_d),
        .Bo (cell_bo)
    );

    assign accept = start && (state_q != RUN);

    always_comb begin
        state_d   = state_q;
        a_sr_d    = a_sr_q;
        b_sr_d    = b_sr_q;
        res_d     = res_q;
        br_d      = br_q;
        cnt_d     = cnt_q;
        diff_d    = diff_q;
        bout_d    = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d     = ovf_q;
`endif
        // Fresh bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
        res_shift = WIDTH'({cell_d, res_q} >> 1);

        case (state_q)
            RUN: begin
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                res_d  = res_shift;
                br_d   = cell_bo;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    diff_d  = res_shift;
                    bout_d  = cell_bo;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d   = br_q ^ cell_bo;
`endif
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            IDLE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Acceptance is identical from IDLE and DONE, enabling back-to-back runs.
        if (accept) begin
            a_sr_d  = a;
            b_sr_d  = b;
            br_d    = bin;
            res_d   = '0;
            cnt_d   = '0;
            state_d = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            res_q   <= res_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign diff = diff_q;
    assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: arithmetic reference model with
// per-cycle compare, directed literal cases and randomized traffic.
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         bin   = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int tests  = 0;
    int fails  = 0;
    bit chk_en = 1'b0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: an accepted request completes W cycles later with
    // the arithmetic result of a - b - bin.
    int           m_left = 0;
    logic         m_done = 1'b0;
    logic [W-1:0] m_diff = '0;
    logic         m_bout = 1'b0;
    logic [W-1:0] p_diff = '0;
    logic         p_bout = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
    logic         m_ovf  = 1'b0;
    logic         p_ovf  = 1'b0;
`endif

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_diff <= '0;
            m_bout <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            m_ovf  <= 1'b0;
`endif
        end else begin
            m_done <= 1'b0;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_done <= 1'b1;
                    m_diff <= p_diff;
                    m_bout <= p_bout;
`ifdef SERIAL_SUB_OVF_EN
                    m_ovf  <= p_ovf;
`endif
                end
            end else if (start) begin
                m_left <= W;
                p_diff <= W'(int'(a) - int'(b) - int'(bin));
                p_bout <= (int'(a) < int'(b) + int'(bin));
`ifdef SERIAL_SUB_OVF_EN
                p_ovf  <= ((int'($signed(a)) - int'($signed(b)) - int'(bin)) < -(2 ** (W - 1))) ||
                          ((int'($signed(a)) - int'($signed(b)) - int'(bin)) > (2 ** (W - 1)) - 1);
`endif
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("busy", int'(busy), int'(m_left > 0));
            checkOutput("done", int'(done), int'(m_done));
            checkOutput("diff", int'(diff), int'(m_diff));
            checkOutput("bout", int'(bout), int'(m_bout));
`ifdef SERIAL_SUB_OVF_EN
            checkOutput("ovf", int'(ovf), int'(m_ovf));
`endif
        end
    end

    task automatic applyStimulus(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic bn);
        @(negedge clk);
        a     = ai;
        b     = bi;
        bin   = bn;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(output int cycles);
        cycles = 0;
        while (!done && cycles < 3 * W + 5) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("done_seen", int'(done), 1);
    endtask

    task automatic runOp(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic bn,
                         input logic [W-1:0] ed, input logic eb);
        int c;
        applyStimulus(ai, bi, bn);
        waitDone(c);
        checkOutput("latency", c, W);
        checkOutput("diff_lit", int'(diff), int'(ed));
        checkOutput("bout_lit", int'(bout), int'(eb));
    endtask

    initial begin
        int nb;
        int nd;
        int c;

        #1 rst_n = 1'b0;
        #1;
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_diff", int'(diff), 0);
        checkOutput("rst_bout", int'(bout), 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        chk_en = 1'b1;

        runOp(4'b0110, 4'b1100, 1'b0, 4'b1010, 1'b1);

        applyStimulus(4'b1010, 4'b0110, 1'b0);
        nb = 0;
        nd = 0;
        repeat (W + 4) begin
            if (busy) nb++;
            if (done) nd++;
            @(negedge clk);
        end
        checkOutput("busy_cycles", nb, 4);
        checkOutput("done_cycles", nd, 1);
        checkOutput("diff_lit", int'(diff), 4'b0100);
        checkOutput("bout_lit", int'(bout), 0);

        runOp(4'b1111, 4'b0010, 1'b1, 4'b1100, 1'b0);
        a     = 4'b0010;
        b     = 4'b1000;
        bin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 1;
        while (!done && c < 20) begin
            @(negedge clk);
            c++;
        end
        checkOutput("b2b_gap", c, 5);
        checkOutput("b2b_diff", int'(diff), 4'b1010);
        checkOutput("b2b_bout", int'(bout), 1);

        applyStimulus(4'b0110, 4'b1100, 1'b0);
        @(negedge clk);
        a     = 4'b0001;
        b     = 4'b0000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nd = 0;
        repeat (2 * W + 4) begin
            @(negedge clk);
            if (done) nd++;
        end
        checkOutput("ign_dones", nd, 1);
        checkOutput("ign_diff", int'(diff), 4'b1010);
        checkOutput("ign_bout", int'(bout), 1);

        applyStimulus(4'b0111, 4'b0011, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_busy", int'(busy), 0);
        checkOutput("mid_rst_done", int'(done), 0);
        checkOutput("mid_rst_diff", int'(diff), 0);
        checkOutput("mid_rst_bout", int'(bout), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        nd = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) nd++;
        end
        checkOutput("post_rst_dones", nd, 0);
        runOp(4'b1010, 4'b0110, 1'b0, 4'b0100, 1'b0);

`ifdef SERIAL_SUB_OVF_EN
        runOp(4'b0111, 4'b1000, 1'b0, 4'b1111, 1'b1);
        checkOutput("ovf_lit", int'(ovf), 1);
        runOp(4'b0110, 4'b0010, 1'b0, 4'b0100, 1'b0);
        checkOutput("ovf_lit", int'(ovf), 0);
`endif

        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 2) == 0);
            a     = W'($urandom);
            b     = W'($urandom);
            bin   = 1'($urandom);
            if (i == 200) begin
                #2 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end
        start = 1'b0;
        repeat (W + 3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
